// File: rtl/fpga_ram_mp.sv
// Multi-requester banked RAM: NCH channels share 2^NBANK_LOG word-interleaved
// single-port banks, each with a round-robin arbiter and read-first byte writes.
module fpga_ram_mp #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned XADR      = 14,
  parameter int unsigned NCH       = 2,
  parameter int unsigned NBANK_LOG = 1,
  parameter int unsigned CW        = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           req_valid,
  output logic [NCH-1:0]           req_ready,
  input  logic [NCH*XLEN/8-1:0]    req_wen,
  input  logic [NCH*XADR-1:0]      req_addr,
  input  logic [NCH*XLEN-1:0]      req_wdata,
  output logic [NCH-1:0]           rsp_valid,
  output logic [NCH*XLEN-1:0]      rsp_rdata,
  output logic [CW-1:0]            stall_cnt
);

  localparam int unsigned NB  = 1 << NBANK_LOG;
  localparam int unsigned NBY = XLEN / 8;
  localparam int unsigned RW  = XADR - NBANK_LOG;
  localparam int unsigned BW  = (NBANK_LOG > 0) ? NBANK_LOG : 1;
  localparam int unsigned PW  = (NCH > 1) ? $clog2(NCH) : 1;

  logic [XADR-1:0] ch_addr [NCH];
  logic [BW-1:0]   ch_bank [NCH];
  logic [RW-1:0]   ch_row  [NCH];

  logic [PW-1:0]   ptr_q   [NB];
  logic [PW-1:0]   ptr_d   [NB];
  logic            gnt_any [NB];
  logic [PW-1:0]   gnt_ch  [NB];

  logic [RW-1:0]   bank_row   [NB];
  logic [NBY-1:0]  bank_wen   [NB];
  logic [XLEN-1:0] bank_wdata [NB];
  logic [XLEN-1:0] bank_rdata [NB];

  logic [NCH-1:0]  rsp_valid_q;
  logic [BW-1:0]   rsp_bank_q [NCH];
  logic [XLEN-1:0] hold_q     [NCH];
  logic [CW-1:0]   stall_q;
  logic            stall_evt;

  // Split each channel's word address into bank index (low bits) and row.
  always_comb begin
    for (int c = 0; c < int'(NCH); c++) begin
      ch_addr[c] = req_addr[c*XADR +: XADR];
      ch_bank[c] = BW'(ch_addr[c] & XADR'(NB - 1));
      ch_row[c]  = RW'(ch_addr[c] >> NBANK_LOG);
    end
  end

  // Per-bank round-robin: first candidate at or after ptr, wrapping modulo NCH.
  always_comb begin
    int unsigned idx;
    req_ready = '0;
    for (int b = 0; b < int'(NB); b++) begin
      gnt_any[b] = 1'b0;
      gnt_ch[b]  = '0;
      ptr_d[b]   = ptr_q[b];
      for (int k = 0; k < int'(NCH); k++) begin
        idx = int'(ptr_q[b]) + k;
        if (idx >= NCH) idx = idx - NCH;
        if (!gnt_any[b] && req_valid[idx] && (ch_bank[idx] == BW'(b))) begin
          gnt_any[b] = 1'b1;
          gnt_ch[b]  = PW'(idx);
        end
      end
      if (rst) gnt_any[b] = 1'b0;
      if (gnt_any[b]) begin
        req_ready[gnt_ch[b]] = 1'b1;
        ptr_d[b] = (gnt_ch[b] == PW'(NCH - 1)) ? '0 : gnt_ch[b] + PW'(1);
      end
    end
  end

  // Route the granted channel's request onto each bank's port.
  always_comb begin
    for (int b = 0; b < int'(NB); b++) begin
      bank_row[b]   = ch_row[gnt_ch[b]];
      bank_wen[b]   = req_wen[int'(gnt_ch[b])*NBY +: NBY];
      bank_wdata[b] = req_wdata[int'(gnt_ch[b])*XLEN +: XLEN];
    end
  end

  for (genvar b = 0; b < int'(NB); b++) begin : g_bank
    logic [XLEN-1:0] mem [2**RW];
    logic [XLEN-1:0] rd_q;

    // Read-first single-port bank: old row contents latched, then masked write.
    always_ff @(posedge clk) begin
      if (gnt_any[b]) begin
        rd_q <= mem[bank_row[b]];
        for (int i = 0; i < int'(NBY); i++) begin
          if (bank_wen[b][i]) mem[bank_row[b]][i*8 +: 8] <= bank_wdata[b][i*8 +: 8];
        end
      end
    end

    assign bank_rdata[b] = rd_q;
  end

  assign stall_evt = (|(req_valid & ~req_ready)) & ~rst;

  // Arbiter pointers, response tracking, held read data and stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
      stall_q     <= '0;
      for (int b = 0; b < int'(NB); b++) ptr_q[b] <= '0;
      for (int c = 0; c < int'(NCH); c++) begin
        rsp_bank_q[c] <= '0;
        hold_q[c]     <= '0;
      end
    end else begin
      rsp_valid_q <= req_ready;
      for (int b = 0; b < int'(NB); b++) ptr_q[b] <= ptr_d[b];
      for (int c = 0; c < int'(NCH); c++) begin
        if (req_ready[c])   rsp_bank_q[c] <= ch_bank[c];
        if (rsp_valid_q[c]) hold_q[c]     <= bank_rdata[rsp_bank_q[c]];
      end
      if (stall_evt && (stall_q != '1)) stall_q <= stall_q + CW'(1);
    end
  end

  // Responses are masked by rst so a reset right after acceptance kills the pulse.
  always_comb begin
    for (int c = 0; c < int'(NCH); c++) begin
      rsp_valid[c] = rsp_valid_q[c] & ~rst;
      if (rst)                 rsp_rdata[c*XLEN +: XLEN] = '0;
      else if (rsp_valid_q[c]) rsp_rdata[c*XLEN +: XLEN] = bank_rdata[rsp_bank_q[c]];
      else                     rsp_rdata[c*XLEN +: XLEN] = hold_q[c];
    end
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_fpga_ram_mp.sv
// Directed bench for fpga_ram_mp at default parameters (NCH=2, two banks).
module tb_fpga_ram_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [7:0]  req_wen = '0;
  logic [27:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  rsp_valid;
  logic [63:0] rsp_rdata;
  logic [31:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpga_ram_mp dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wen   (req_wen),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .stall_cnt (stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int c, input logic v, input logic [3:0] wen,
                       input logic [13:0] addr, input logic [31:0] wd);
    req_valid[c]          = v;
    req_wen[c*4 +: 4]     = wen;
    req_addr[c*14 +: 14]  = addr;
    req_wdata[c*32 +: 32] = wd;
  endtask

  task automatic idle();
    req_valid = '0;
    req_wen   = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic pulse_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Known contents at 0x10 so later reads have a defined expectation.
  task automatic preload();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    drive(0, 1'b1, 4'hF, 14'h10, 32'h0000_0000);
    tick();
    idle();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 1'b1, 4'hF, 14'h10, 32'hAAAA_AAAA);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (req_ready !== 2'b00) begin
        errors++; $display("FAIL reset_ready: got %b exp 00", req_ready);
      end
      tick();
      checks++;
      if (rsp_valid !== 2'b00 || stall_cnt !== 32'd0) begin
        errors++;
        $display("FAIL reset_rsp_stall: valid %b stall %0d exp 00 0", rsp_valid, stall_cnt);
      end
    end
    checks++;
    if (rsp_rdata !== 64'd0) begin
      errors++; $display("FAIL reset_rdata: got %h exp 0", rsp_rdata);
    end
    rst = 1'b0;
    drive(0, 1'b1, 4'h0, 14'h10, 32'h0);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL reset_read_ready: got %b exp 01", req_ready);
    end
    tick();
    idle();
    checks++;
    if (rsp_valid !== 2'b01 || rsp_rdata[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_no_write: valid %b data %h exp 01 00000000", rsp_valid, rsp_rdata[31:0]);
    end
    tick();
  endtask

  task automatic test_write_read();
    drive(0, 1'b1, 4'hF, 14'h10, 32'hDEAD_BEEF);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL wr_ready: got %b exp 01", req_ready);
    end
    tick();
    drive(0, 1'b1, 4'h0, 14'h10, 32'h0);
    checks++;
    if (rsp_valid !== 2'b01 || rsp_rdata[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL wr_rsp_old: valid %b data %h exp 01 00000000", rsp_valid, rsp_rdata[31:0]);
    end
    tick();
    idle();
    checks++;
    if (rsp_valid !== 2'b01 || rsp_rdata[31:0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd_data: valid %b data %h exp 01 deadbeef", rsp_valid, rsp_rdata[31:0]);
    end
    tick();
    checks++;
    if (rsp_valid !== 2'b00 || rsp_rdata[31:0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rd_hold: valid %b data %h exp 00 deadbeef", rsp_valid, rsp_rdata[31:0]);
    end
  endtask

  task automatic test_byte_en();
    drive(0, 1'b1, 4'b0101, 14'h10, 32'h1122_3344);
    tick();
    drive(0, 1'b1, 4'h0, 14'h10, 32'h0);
    checks++;
    if (rsp_rdata[31:0] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL be_old: got %h exp deadbeef", rsp_rdata[31:0]);
    end
    tick();
    idle();
    checks++;
    if (rsp_valid !== 2'b01 || rsp_rdata[31:0] !== 32'hDE22_BE44) begin
      errors++;
      $display("FAIL be_merge: valid %b data %h exp 01 de22be44", rsp_valid, rsp_rdata[31:0]);
    end
    tick();
  endtask

  task automatic test_conflict();
    logic [1:0] exp_g [4];
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    pulse_reset();
    drive(0, 1'b1, 4'h0, 14'h10, 32'h0);
    drive(1, 1'b1, 4'h0, 14'h20, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (req_ready !== exp_g[i]) begin
        errors++; $display("FAIL conflict_grant%0d: got %b exp %b", i, req_ready, exp_g[i]);
      end
      tick();
      checks++;
      if (rsp_valid !== exp_g[i]) begin
        errors++; $display("FAIL conflict_rsp%0d: got %b exp %b", i, rsp_valid, exp_g[i]);
      end
    end
    idle();
    checks++;
    if (stall_cnt !== 32'd4) begin
      errors++; $display("FAIL conflict_stall: got %0d exp 4", stall_cnt);
    end
    tick();
  endtask

  task automatic test_parallel();
    drive(0, 1'b1, 4'h0, 14'h10, 32'h0);
    drive(1, 1'b1, 4'h0, 14'h11, 32'h0);
    #1;
    checks++;
    if (req_ready !== 2'b11) begin
      errors++; $display("FAIL par_ready: got %b exp 11", req_ready);
    end
    tick();
    idle();
    checks++;
    if (rsp_valid !== 2'b11 || rsp_rdata[31:0] !== 32'hDE22_BE44) begin
      errors++;
      $display("FAIL par_rsp: valid %b data %h exp 11 de22be44", rsp_valid, rsp_rdata[31:0]);
    end
    checks++;
    if (stall_cnt !== 32'd4) begin
      errors++; $display("FAIL par_stall: got %0d exp 4", stall_cnt);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    // Leave bank-0 pointer at ch1 so only a reset can bring it back to ch0.
    drive(0, 1'b1, 4'h0, 14'h10, 32'h0);
    tick();
    idle();
    drive(1, 1'b1, 4'h0, 14'h11, 32'h0);
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++; $display("FAIL mid_ready: got %b exp 10", req_ready);
    end
    tick();
    idle();
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 2'b00 || rsp_rdata !== 64'd0) begin
      errors++; $display("FAIL mid_suppress: valid %b data %h exp 00 0", rsp_valid, rsp_rdata);
    end
    tick();
    checks++;
    if (rsp_valid !== 2'b00 || stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL mid_after: valid %b stall %0d exp 00 0", rsp_valid, stall_cnt);
    end
    rst = 1'b0;
    drive(0, 1'b1, 4'h0, 14'h10, 32'h0);
    drive(1, 1'b1, 4'h0, 14'h20, 32'h0);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL mid_ptr: got %b exp 01", req_ready);
    end
    tick();
    idle();
    checks++;
    if (rsp_valid !== 2'b01 || rsp_rdata[31:0] !== 32'hDE22_BE44) begin
      errors++;
      $display("FAIL mid_rsp: valid %b data %h exp 01 de22be44", rsp_valid, rsp_rdata[31:0]);
    end
    tick();
  endtask

  initial begin
    preload();
    test_reset();
    test_write_read();
    test_byte_en();
    test_conflict();
    test_parallel();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
